// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Parametrised UART transmitter. It sends 5..DATA_SIZE data bits, an optional
// even/odd parity bit and 1 or 2 stop bits. Data goes out LSB first and each
// bit lasts OVERSAMPLE s_ticks. Words arrive through a valid/ready handshake.
// The frame configuration is captured when a word is accepted, so changes to
// cfg_* during a frame take effect only from the next frame.
//
// Optional build macro: UART_TX_BREAK_EN. It adds the break_req input and a
// BREAK state: the line is held low while break_req is high, then driven
// high for one bit period (mark-after-break) before returning to IDLE.
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   s_tick         oversampling tick, one clk wide
//   cfg_data_bits  data bits per frame (clamped to 5..DATA_SIZE)
//   cfg_parity_en  1 = parity bit present
//   cfg_parity_odd 1 = odd parity, 0 = even
//   cfg_stop2      1 = two stop bits
//   tx_valid       data_in valid
//   tx_ready       block can accept a word (combinational from state)
//   data_in        word to send, LSB first
//   break_req      (UART_TX_BREAK_EN only) request a line break
//   tx             serial line, idle high (registered)
//   tx_busy        frame in progress
//   tx_done_tick   one-clk registered pulse at frame end
module uart_tx_frame #(
  parameter int DATA_SIZE         = 8,
  parameter int OVERSAMPLE        = 16,
  parameter int BIT_COUNT_SIZE    = $clog2(DATA_SIZE + 1),
  parameter int SAMPLE_COUNT_SIZE = $clog2(OVERSAMPLE)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_tick,
  input  logic [BIT_COUNT_SIZE-1:0] cfg_data_bits,
  input  logic                      cfg_parity_en,
  input  logic                      cfg_parity_odd,
  input  logic                      cfg_stop2,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic [DATA_SIZE-1:0]      data_in,
`ifdef UART_TX_BREAK_EN
  input  logic                      break_req,
`endif
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      tx_done_tick
);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

  state_t                       state_q, state_d;
  logic [SAMPLE_COUNT_SIZE-1:0] sample_cnt;
  logic [BIT_COUNT_SIZE-1:0]    bit_cnt;
  logic [DATA_SIZE-1:0]         shreg;
  logic [BIT_COUNT_SIZE-1:0]    nbits_q;
  logic                         par_en_q, par_odd_q, stop2_q;
  logic                         par_q;        // running XOR of sent data bits
  logic                         stop_second;  // first of two stop bits done
  logic                         brk_mark;     // in mark-after-break phase
  logic                         tx_q, done_q;
  logic                         bit_end, last_data, cnt_run;

  // Out-of-range data-bit requests are folded into the supported range.
  function automatic logic [BIT_COUNT_SIZE-1:0] clamp_bits(
    input logic [BIT_COUNT_SIZE-1:0] b);
    if (b < BIT_COUNT_SIZE'(5))
      return BIT_COUNT_SIZE'(5);
    else if (b > BIT_COUNT_SIZE'(DATA_SIZE))
      return BIT_COUNT_SIZE'(DATA_SIZE);
    else
      return b;
  endfunction

  assign bit_end   = s_tick && (sample_cnt == SAMPLE_COUNT_SIZE'(OVERSAMPLE - 1));
  assign last_data = (bit_cnt == nbits_q - BIT_COUNT_SIZE'(1));

  // The sample counter is idle in IDLE and while the break is being held.
  always_comb begin
    cnt_run = (state_q != IDLE);
`ifdef UART_TX_BREAK_EN
    if (state_q == BREAK && !brk_mark)
      cnt_run = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req)
          state_d = BREAK;
        else if (tx_valid)
          state_d = START;
`else
        if (tx_valid)
          state_d = START;
`endif
      end
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end && (!stop2_q || stop_second)) state_d = IDLE;
`ifdef UART_TX_BREAK_EN
      BREAK:  if (brk_mark && bit_end) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_ready     = (state_q == IDLE) && reset_n;
    tx_busy      = (state_q != IDLE);
    tx           = tx_q;
    tx_done_tick = done_q;
  end

  // Datapath: counters, shift register, shadow config and the registered line.
  // Each bit value is registered onto tx on the same edge that ends the
  // previous bit, so tx never glitches between bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shreg       <= '1;
      nbits_q     <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      par_q       <= 1'b0;
      stop_second <= 1'b0;
      brk_mark    <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (!cnt_run)
        sample_cnt <= '0;
      else if (s_tick)
        sample_cnt <= bit_end ? '0 : sample_cnt + SAMPLE_COUNT_SIZE'(1);

      case (state_q)
        IDLE: begin
          bit_cnt     <= '0;
          par_q       <= 1'b0;
          stop_second <= 1'b0;
          brk_mark    <= 1'b0;
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            tx_q <= 1'b0;
          end else
`endif
          if (tx_valid) begin
            shreg     <= data_in;
            nbits_q   <= clamp_bits(cfg_data_bits);
            par_en_q  <= cfg_parity_en;
            par_odd_q <= cfg_parity_odd;
            stop2_q   <= cfg_stop2;
            tx_q      <= 1'b0;
          end
        end
        START: begin
          if (bit_end)
            tx_q <= shreg[0];
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= {1'b1, shreg[DATA_SIZE-1:1]};
            bit_cnt <= bit_cnt + BIT_COUNT_SIZE'(1);
            par_q   <= par_q ^ shreg[0];
            if (last_data)
              tx_q <= par_en_q ? (par_q ^ shreg[0] ^ par_odd_q) : 1'b1;
            else
              tx_q <= shreg[1];
          end
        end
        PARITY: begin
          if (bit_end)
            tx_q <= 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              done_q <= 1'b1;
              tx_q   <= 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          // Hold low until the request drops, then one bit period of mark.
          if (!brk_mark) begin
            if (!break_req) begin
              brk_mark <= 1'b1;
              tx_q     <= 1'b1;
            end
          end else if (bit_end) begin
            brk_mark <= 1'b0;
          end
        end
`endif
        default: tx_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame (DATA_SIZE=8, OVERSAMPLE=16).
// Expected frames are hand-written bit patterns: bit i of a pattern is the
// line level during frame bit i (start, data LSB first, parity, stops).
module tb_uart_tx_frame;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic [3:0] cfg_data_bits = 4'd8;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_odd = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
`ifdef UART_TX_BREAK_EN
  logic       break_req = 1'b0;
`endif
  logic       tx_ready, tx, tx_busy, tx_done_tick;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  uart_tx_frame #(.DATA_SIZE(8), .OVERSAMPLE(OS)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_tick(s_tick),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2(cfg_stop2),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .data_in(data_in),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_done_tick) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One s_tick; returns just after the clk edge that counted it.
  task automatic tick();
    @(negedge clk) s_tick = 1'b1;
    @(negedge clk) s_tick = 1'b0;
  endtask

  // Present a word for one clk and check the start bit is on the line.
  task automatic accept(input logic [7:0] d, input logic with_tick, input string tag);
    @(negedge clk);
    tx_valid = 1'b1;
    data_in  = d;
    s_tick   = with_tick;
    @(negedge clk);
    tx_valid = 1'b0;
    s_tick   = 1'b0;
    chk({tag, " start tx"}, tx, 0);
    chk({tag, " start rdy"}, tx_ready, 0);
    chk({tag, " start busy"}, tx_busy, 1);
  endtask

  // Tick through a whole frame of len bits, checking tx at each bit
  // boundary and mid-bit, and the done pulse on the final tick.
  task automatic run_frame(input logic [15:0] bits, input int len, input string tag);
    int total;
    total = len * OS;
    for (int n = 1; n <= total; n++) begin
      tick();
      if (n < total) begin
        if (n % OS == 0 || n % OS == 8)
          chk($sformatf("%s tx@%0d", tag, n), tx, bits[n / OS]);
        if (n % OS == 8) begin
          chk($sformatf("%s rdy@%0d", tag, n), tx_ready, 0);
          chk($sformatf("%s done@%0d", tag, n), tx_done_tick, 0);
        end
      end else begin
        chk({tag, " done pulse"}, tx_done_tick, 1);
        chk({tag, " end tx"}, tx, 1);
        chk({tag, " end rdy"}, tx_ready, 1);
        chk({tag, " end busy"}, tx_busy, 0);
      end
    end
  endtask

  task automatic post(input int exp, input string tag);
    @(negedge clk);
    chk({tag, " done width"}, tx_done_tick, 0);
    chk({tag, " done count"}, done_cnt, exp);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", tx_busy, 0);
    reset_n = 1'b1;
    #1;
    chk("reset rdy", tx_ready, 1);
    chk("reset done", tx_done_tick, 0);
    chk("reset tx after release", tx, 1);

    // 8N1, 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    accept(8'hA5, 1'b0, "8N1");
    run_frame(16'h034A, 10, "8N1");
    post(1, "8N1");

    // 7E2, 0xD5 (bit7 ignored) -> 0,1,0,1,0,1,0,1,0,1,1
    cfg_data_bits = 4'd7; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
    accept(8'hD5, 1'b0, "7E2");
    run_frame(16'h06AA, 11, "7E2");
    post(2, "7E2");

    // 8O1, 0x00, s_tick high on the accept edge, cfg changed mid-frame
    cfg_data_bits = 4'd8; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1; cfg_stop2 = 1'b0;
    accept(8'h00, 1'b1, "8O1");
    cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1; cfg_data_bits = 4'd5;
    run_frame(16'h0600, 11, "8O1");
    post(3, "8O1");

    // cfg_data_bits=2 clamps to 5: 0x35 -> 0,1,0,1,0,1,1
    cfg_data_bits = 4'd2; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    accept(8'h35, 1'b0, "clamp5");
    run_frame(16'h006A, 7, "clamp5");
    post(4, "clamp5");

    // Back-to-back with tx_valid held: 0x3C then 0xC3
    cfg_data_bits = 4'd8;
    @(negedge clk);
    tx_valid = 1'b1;
    data_in  = 8'h3C;
    @(negedge clk);
    data_in  = 8'hC3;
    chk("b2b1 start tx", tx, 0);
    run_frame(16'h0278, 10, "b2b1");
    @(negedge clk);
    chk("b2b2 start tx", tx, 0);
    chk("b2b2 start rdy", tx_ready, 0);
    tx_valid = 1'b0;
    run_frame(16'h0386, 10, "b2b2");
    post(6, "b2b");

    // Reset during data bit 3
    accept(8'hA5, 1'b0, "rst");
    for (int i = 0; i < 4 * OS + 8; i++) tick();
    chk("rst mid-frame busy", tx_busy, 1);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("rst tx", tx, 1);
    chk("rst rdy", tx_ready, 1);
    chk("rst busy", tx_busy, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("rst idle tx", tx, 1);
    chk("rst no done", done_cnt, 6);
    accept(8'h3C, 1'b0, "after rst");
    run_frame(16'h0278, 10, "after rst");
    post(7, "after rst");

`ifdef UART_TX_BREAK_EN
    // Break for 40 ticks with a word waiting, then 16 ticks of mark
    @(negedge clk);
    break_req = 1'b1;
    tx_valid  = 1'b1;
    data_in   = 8'hA5;
    @(negedge clk);
    chk("brk tx", tx, 0);
    chk("brk rdy", tx_ready, 0);
    chk("brk busy", tx_busy, 1);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n % 8 == 0) begin
        chk($sformatf("brk low tx@%0d", n), tx, 0);
        chk($sformatf("brk low rdy@%0d", n), tx_ready, 0);
      end
    end
    @(negedge clk) break_req = 1'b0;
    for (int n = 1; n <= OS; n++) begin
      tick();
      if (n < OS) begin
        if (n % 4 == 0) begin
          chk($sformatf("mark tx@%0d", n), tx, 1);
          chk($sformatf("mark rdy@%0d", n), tx_ready, 0);
        end
      end else begin
        chk("mark end tx", tx, 1);
        chk("mark end rdy", tx_ready, 1);
        chk("mark no done", tx_done_tick, 0);
      end
    end
    @(negedge clk);
    chk("post-brk start tx", tx, 0);
    tx_valid = 1'b0;
    run_frame(16'h034A, 10, "post-brk");
    post(8, "post-brk");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
